scan_chain_ctrl: RTL
====================

# scan_chain_ctrl

Word-serial master for the `scff` scan/configuration chain, driving the chain head and collecting its tail. It accepts configuration words on a valid/ready port and shifts them LSB-first into the chain through `scan_si`. In the same cycles it captures the previous chain contents from `scan_so` and returns them as readback words on a second valid/ready port. The block sits between the configuration/test access logic and the fabric scan chain, and it owns the chain's scan-enable and clock-enable.

## Interface
- `CHAIN_LEN`, 64: number of cells in the chain; must be a nonzero multiple of `WORD_W`.
- `WORD_W`, 8: width of the write and readback words; N = `CHAIN_LEN`/`WORD_W` words per operation.
- `SO_INV`, 0: 1 means the tail output is inverted (the `scff` SO pin); captured bits are inverted before packing.

- `clk`  in  1  clock; the chain is clocked by the same clock, gated by `scan_ce`.
- `R`  in  1  reset; one clock; reset is synchronous and active-high.
- `start`  in  1  begin an operation; sampled only in IDLE.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `wr_data`  in  WORD_W  next configuration word.
- `wr_valid`  in  1  write handshake.
- `wr_ready`  out  1  write handshake.
- `rd_data`  out  WORD_W  readback word.
- `rd_valid`  out  1  readback handshake.
- `rd_ready`  in  1  readback handshake.
- `scan_en`  out  1  drives the chain `E` pins (1 selects `SI`).
- `scan_ce`  out  1  chain clock enable; the chain shifts at every edge where it is 1.
- `scan_si`  out  1  serial data into the chain head.
- `scan_so`  in  1  chain tail output.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. A word counter runs 0..N-1 and a bit counter runs 0..WORD_W-1. The block holds a WORD_W shift register, a WORD_W capture register and a single-entry readback register.
- **IDLE**
  - `busy`=0 and `scan_en`=0.
  - `start`=1 → LOAD, word counter cleared.
- **LOAD**
  - `wr_ready` = `wr_valid`-independent, and is 1 iff the readback slot is free. The slot is free when `rd_valid`=0, or when `rd_valid`=1 and `rd_ready`=1 in this cycle.
  - On a write handshake: the word is latched into the shift register, the bit counter is cleared, and the state goes to SHIFT.
- **SHIFT**
  - Lasts exactly WORD_W cycles; no stalling inside a word.
  - `scan_ce`=1 and `scan_si` = shift register bit 0.
  - At each edge: the shift register shifts right, and `scan_so` (XOR `SO_INV`) enters the capture register MSB, shifting right.
  - On the last bit: `rd_data` is loaded with the completed capture word and `rd_valid` is set.
  - After the last bit, the state goes to DONE if word counter = N-1; otherwise the word counter increments and the state goes to LOAD.
- **DONE**
  - Waits for the last readback handshake.
  - Then `done` pulses for one cycle and the state returns to IDLE.
- `scan_en` = 1 in LOAD, SHIFT and DONE. `scan_ce` = 1 only in SHIFT. Outside SHIFT the chain is frozen; there is no functional capture.
- Chain model used for ordering: on each `scan_ce` edge, chain ← {si, chain[L-1:1]}, and `scan_so` = chain[0].
  - The first bit shifted in ends at the tail, so the final chain contents are {word N-1, …, word 0}.
  - Readback word k holds old chain bits [k·W+W-1 : k·W].
- `rd_valid` clears on a handshake. It is never overwritten while pending, because LOAD gates on the free slot.
- `start` is ignored outside IDLE.
- A reset in any state, at the next edge:
  - state returns to IDLE, and `busy`, `done`, `rd_valid`, `scan_en` and `scan_ce` go to 0;
  - the counters, registers and `rd_data` are cleared;
  - `done` is not pulsed;
  - the chain contents after a reset are partially shifted and undefined to software.

## Timing
- Reset values: all outputs 0, including `rd_data` = 0 and `wr_ready` = 0.
- `start` sampled at edge 0 → LOAD in cycle 1.
- Each word costs 1 LOAD cycle (minimum) plus WORD_W SHIFT cycles.
- `rd_valid` rises in the first cycle after the last shift cycle of a word.
- `done` is high in the cycle after the final readback handshake; `busy` is 0 in that same cycle.
- With `wr_valid`=`rd_ready`=1 continuously, `done` comes at cycle N·(WORD_W+1)+2 after the start edge.
- `wr_ready` is combinational from state and the readback handshake. All other outputs are registered or decoded from registered state.

## Test plan
- **Basic load and readback.** CHAIN_LEN=16, WORD_W=8, SO_INV=0, chain model preloaded with 0xBEEF, writes 0x12 then 0x34, `rd_ready`=1 → readback 0xEF then 0xBE, chain = 0x3412, `done` in cycle 20, exactly 16 `scan_ce` cycles.
- **Write back-pressure.** Same setup, `wr_valid` low for 5 cycles before the second word → `scan_ce`=0 and the chain is held during the gap; identical data; `done` in cycle 25.
- **Readback back-pressure.** `rd_ready` low for 6 cycles after the first `rd_valid` → `wr_ready` stays 0 and no shifting occurs until the handshake; `rd_data` stays 0xEF throughout.
- **Reset mid-shift.** `R` pulsed during the 4th SHIFT cycle of word 0 → next cycle `busy`, `scan_en`, `scan_ce`, `rd_valid` and `done` are all 0. A following clean operation from a chain preloaded with 0xBEEF returns correct data.
- **Inverted tail and ignored start.** SO_INV=1 with the chain model outputting ~chain[0] → readback still 0xEF, 0xBE. A `start` pulse mid-operation has no effect.
- **Maximum length.** CHAIN_LEN=64, WORD_W=8, random 8 words with `rd_ready` always high → readback equals the previous contents, chain equals the written words, `done` in cycle 74.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Word-serial master for the scff scan/configuration chain: shifts write words into the
// chain head LSB-first while packing the old chain contents from the tail into readback words.
`timescale 1ns/1ps
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter bit SO_INV    = 1'b0
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              scan_en,
    output logic              scan_ce,
    output logic              scan_si,
    input  logic              scan_so
);
    localparam int N   = CHAIN_LEN / WORD_W;
    localparam int WCW = (N > 1) ? $clog2(N) : 1;
    localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [WCW-1:0]    word_cnt_r;
    logic [BCW-1:0]    bit_cnt_r;
    logic [WORD_W-1:0] shift_r;
    logic [WORD_W-1:0] cap_r;
    logic [WORD_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              done_r;

    logic              rd_take_s;
    logic              slot_free_s;
    logic              wr_ready_s;
    logic              wr_take_s;
    logic              so_bit_s;
    logic              last_bit_s;
    logic              last_word_s;
    logic [WORD_W-1:0] cap_next_s;

    // Shift right by one and insert a bit at the MSB.
    function automatic logic [WORD_W-1:0] shr_in(input logic [WORD_W-1:0] v, input logic b);
        logic [WORD_W-1:0] r;
        r = v >> 1;
        r[WORD_W-1] = b;
        return r;
    endfunction

    assign rd_take_s   = rd_valid_r & rd_ready;
    assign slot_free_s = ~rd_valid_r | rd_ready;
    assign wr_ready_s  = (state_r == S_LOAD) & slot_free_s;
    assign wr_take_s   = wr_ready_s & wr_valid;
    assign so_bit_s    = scan_so ^ SO_INV;
    assign last_bit_s  = (bit_cnt_r == BCW'(WORD_W - 1));
    assign last_word_s = (word_cnt_r == WCW'(N - 1));
    assign cap_next_s  = shr_in(cap_r, so_bit_s);

    // Operation sequencer, datapath registers and readback slot.
    always_ff @(posedge clk) begin
        if (R) begin
            state_r    <= S_IDLE;
            word_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            cap_r      <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (rd_take_s) begin
                rd_valid_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        word_cnt_r <= '0;
                        state_r    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (wr_take_s) begin
                        shift_r   <= wr_data;
                        bit_cnt_r <= '0;
                        state_r   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_r <= shift_r >> 1;
                    cap_r   <= cap_next_s;
                    if (last_bit_s) begin
                        // Slot is guaranteed free here: LOAD only advances when it is.
                        rd_data_r  <= cap_next_s;
                        rd_valid_r <= 1'b1;
                        bit_cnt_r  <= '0;
                        if (last_word_s) begin
                            state_r <= S_DONE;
                        end else begin
                            word_cnt_r <= word_cnt_r + WCW'(1);
                            state_r    <= S_LOAD;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BCW'(1);
                    end
                end
                S_DONE: begin
                    if (!rd_valid_r || rd_ready) begin
                        done_r  <= 1'b1;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_r != S_IDLE);
    assign scan_en  = (state_r != S_IDLE);
    assign scan_ce  = (state_r == S_SHIFT);
    assign scan_si  = shift_r[0];
    assign wr_ready = wr_ready_s;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign done     = done_r;
endmodule
